periph_bus: RTL and testbench
=============================

# periph_bus

Memory-mapped peripheral responder for the single-cycle MIPS core. It decodes CPU data-memory accesses in the 0x4000_0000 window and returns read data combinationally, in the same cycle as the instruction fetch. It owns the timer (TH/TL/TCON) and the LED, switch and 7-segment registers. It also owns the register-side handshake to the external UART receiver and transmitter. It is the responder for the polling, GCD and timer-interrupt code the core executes.

## Interface
- BASE_ADDR, 32'h4000_0000: window base; only addr[31:6] == BASE_ADDR[31:6] selects this block.
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- rd  in  1  CPU load strobe (MemRead)
- wr  in  1  CPU store strobe (MemWrite)
- addr  in  32  byte address; word offset is addr[5:2]
- wdata  in  32  store data
- rdata  out  32  load data, combinational; 0 when not selected or !rd
- irqout  out  1  timer interrupt request to the core
- led  out  8  LED register
- switch  in  8  board switches
- digi  out  12  7-segment register: [11:8] anode select, [7:0] segment pattern
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- tx_data  out  8  byte to uart_tx
- tx_start  out  1  one-cycle launch pulse to uart_tx
- tx_busy  in  1  uart_tx is shifting

## Operation
Register map (byte offset):
- 0x00 TH (RW, 32 bits).
- 0x04 TL (RW, 32 bits).
- 0x08 TCON (RW, bits [2:0]; other bits read 0).
  - bit0: count enable.
  - bit1: interrupt enable.
  - bit2: interrupt status.
- 0x0C led (RW).
- 0x10 switch (RO; writes ignored).
- 0x14 digi (RW).
- 0x18 RXCNT (RO): number of bytes received since the last clear, 0..2, zero-extended.
- 0x1C RX0 (RO): first operand byte.
- 0x20 RX1 (RO): second operand byte.
- 0x24 TXD (WO): writing wdata[7:0] requests a transmission. Reads return 0.
- 0x28 TXSTAT (RO): bit0 = tx_busy, bit1 = tx_pending.
- Other offsets read 0; writes to them are ignored.

Timer:
- While TCON[0] = 1, TL increments by 1 every clk.
- When TL = 32'hFFFF_FFFF at an edge, TL is loaded with TH. In the same edge, TCON[2] is set if TCON[1] = 1.
- irqout = TCON[2] & TCON[1].
- A CPU write to TL or TCON in the same cycle as the increment/reload wins over it.

UART RX:
- On rx_valid with RXCNT = 0, the byte goes to RX0 and RXCNT becomes 1.
- On rx_valid with RXCNT = 1, the byte goes to RX1 and RXCNT becomes 2.
- On rx_valid with RXCNT = 2, the byte is dropped (overrun).
- A load from 0x20 (rd && selected) clears RXCNT to 0 at the clock edge. RX0 and RX1 keep their values.
- rx_valid in the same cycle as a clearing load: the clear happens first, then the byte is stored into RX0 and RXCNT becomes 1.

UART TX, one-deep holding buffer:
- TXD write while !tx_busy and !tx_pending: tx_data is loaded and tx_start pulses in the next cycle.
- TXD write while busy: the byte is held and tx_pending is set. When tx_busy falls, tx_start pulses and tx_pending clears.
- TXD write while tx_pending = 1: the held byte is overwritten; still only one launch.

## Timing
- Reads are combinational, zero latency. All register updates happen on the rising clk edge.
- Values after reset: TH, TL, TCON, led, digi, RXCNT, RX0, RX1, tx_data = 0; tx_start = 0; tx_pending = 0; irqout = 0.
- tx_start is asserted for exactly one cycle per accepted byte. It is never asserted while tx_busy = 1.
- Reset asserted mid-transmission drops the pending byte. tx_start is not re-issued after reset releases.

## Configuration
- PERIPH_TIMER_EN defined: the timer is built as specified.
- PERIPH_TIMER_EN undefined:
  - offsets 0x00–0x08 read 0 and ignore writes;
  - irqout is tied to 0;
  - no timer flops are synthesised.

## Structure
- Package periph_pkg holds:
  - offset localparams: OFF_TH, OFF_TL, OFF_TCON, OFF_LED, OFF_SW, OFF_DIGI, OFF_RXCNT, OFF_RX0, OFF_RX1, OFF_TXD, OFF_TXSTAT;
  - TCON bit indices: TCON_EN, TCON_IE, TCON_IS.
- One sub-module, periph_timer, contains TH, TL, TCON and irqout. It is instantiated under PERIPH_TIMER_EN.
- Address decode, the RX registers and the TX buffer live in the top level.

## Test plan
- Reset, then write TH = 32'hFFFF_FFFC, TL = 32'hFFFF_FFFE, TCON = 3 → irqout rises 2 cycles after TCON is written; TL reads TH+1 on the following cycle.
- Two rx_valid strobes with 8'h24 then 8'h3C → RXCNT reads 2, RX0 = 0x24, RX1 = 0x3C; a load from 0x20 leaves RXCNT = 0 and RX1 still 0x3C.
- Third rx_valid (8'hFF) while RXCNT = 2 → RX0/RX1 unchanged, RXCNT stays 2.
- Write TXD = 0x0C while tx_busy = 1, then drop tx_busy → exactly one tx_start pulse, with tx_data = 0x0C, in the cycle after tx_busy falls.
- Write led = 0xA5 and digi = 0x1C0; load 0x10 with switch = 0x5A → outputs 0xA5 and 0x1C0; rdata = 0x0000_005A; a store to 0x10 changes nothing.
- Build without PERIPH_TIMER_EN, write TCON = 3 → a load from 0x08 returns 0 and irqout stays 0.

Source files
------------

// File: rtl/periph_pkg.sv
// periph_pkg: shared constants and types for the periph_bus peripheral responder.
//   BASE_ADDR      : address window base; only addr[31:6] takes part in the decode
//   OFF_*          : byte offsets of the memory-mapped registers inside the window
//   TCON_*         : bit indices inside the timer control register
//   tmr_wr_t       : per-register write strobes handed to the timer
// Optional feature macro used by the RTL: PERIPH_TIMER_EN.
package periph_pkg;

  localparam logic [31:0] BASE_ADDR = 32'h4000_0000;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LED_W  = 8;
  localparam int unsigned SW_W   = 8;
  localparam int unsigned DIGI_W = 12;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned TCON_W = 3;
  localparam int unsigned RXCNT_W = 2;

  localparam logic [OFF_W-1:0] OFF_TH     = 6'h00;
  localparam logic [OFF_W-1:0] OFF_TL     = 6'h04;
  localparam logic [OFF_W-1:0] OFF_TCON   = 6'h08;
  localparam logic [OFF_W-1:0] OFF_LED    = 6'h0C;
  localparam logic [OFF_W-1:0] OFF_SW     = 6'h10;
  localparam logic [OFF_W-1:0] OFF_DIGI   = 6'h14;
  localparam logic [OFF_W-1:0] OFF_RXCNT  = 6'h18;
  localparam logic [OFF_W-1:0] OFF_RX0    = 6'h1C;
  localparam logic [OFF_W-1:0] OFF_RX1    = 6'h20;
  localparam logic [OFF_W-1:0] OFF_TXD    = 6'h24;
  localparam logic [OFF_W-1:0] OFF_TXSTAT = 6'h28;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IS = 2;

  // Write strobes for the three timer registers.
  typedef struct packed {
    logic th;
    logic tl;
    logic tcon;
  } tmr_wr_t;

endpackage

// File: rtl/periph_timer.sv
// periph_timer: TH/TL/TCON reload timer with interrupt request.
//   clk_i    : system clock
//   rst_ni   : synchronous active-low reset
//   wr_i     : per-register CPU write strobes (TH, TL, TCON)
//   wdata_i  : CPU store data
//   th_o     : TH reload value
//   tl_o     : TL running count
//   tcon_o   : TCON [2]=status [1]=irq enable [0]=count enable
//   irq_o    : interrupt request (status & enable)
// Only instantiated when PERIPH_TIMER_EN is defined.
module periph_timer
  import periph_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  tmr_wr_t           wr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] th_o,
  output logic [DATA_W-1:0] tl_o,
  output logic [TCON_W-1:0] tcon_o,
  output logic              irq_o
);

  logic [DATA_W-1:0] th_q, th_d;
  logic [DATA_W-1:0] tl_q, tl_d;
  logic [TCON_W-1:0] tcon_q, tcon_d;

  // Count/reload first, then let CPU writes override the same edge.
  always_comb begin
    th_d   = th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[TCON_EN]) begin
      if (tl_q == '1) begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) begin
          tcon_d[TCON_IS] = 1'b1;
        end
      end else begin
        tl_d = tl_q + DATA_W'(1);
      end
    end
    if (wr_i.th)   th_d   = wdata_i;
    if (wr_i.tl)   tl_d   = wdata_i;
    if (wr_i.tcon) tcon_d = wdata_i[TCON_W-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;
  assign irq_o  = tcon_q[TCON_IS] & tcon_q[TCON_IE];

  logic unused_wdata;
  assign unused_wdata = ^wdata_i[DATA_W-1:TCON_W];

endmodule

// File: rtl/periph_bus.sv
// periph_bus: memory-mapped peripheral responder in the 0x4000_0000 window.
//   clk, reset       : system clock, synchronous active-low reset
//   rd, wr           : CPU load / store strobes
//   addr, wdata      : byte address (word offset addr[5:2]) and store data
//   rdata            : combinational load data, 0 when unselected or !rd
//   irqout           : timer interrupt request
//   led, switch, digi: board LEDs, switches, 7-segment register
//   rx_data/rx_valid : byte strobe from the UART receiver
//   tx_data/tx_start : byte and one-cycle launch pulse to the UART transmitter
//   tx_busy          : UART transmitter is shifting
// Macro PERIPH_TIMER_EN builds the TH/TL/TCON timer; without it those
// offsets read 0, writes are ignored and irqout is tied low.
module periph_bus
  import periph_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irqout,
  output logic [LED_W-1:0]  led,
  input  logic [SW_W-1:0]   switch,
  output logic [DIGI_W-1:0] digi,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_start,
  input  logic              tx_busy
);

  // Address decode
  logic             sel;
  logic             rd_sel;
  logic             wr_sel;
  logic [OFF_W-1:0] off;

  assign sel    = (addr[ADDR_W-1:OFF_W] == BASE_ADDR[ADDR_W-1:OFF_W]);
  assign off    = {addr[OFF_W-1:2], 2'b00};
  assign rd_sel = rd && sel;
  assign wr_sel = wr && sel;

  logic unused_addr;
  assign unused_addr = ^addr[1:0];

  // Timer (optional)
  logic [DATA_W-1:0] th_rd;
  logic [DATA_W-1:0] tl_rd;
  logic [TCON_W-1:0] tcon_rd;

`ifdef PERIPH_TIMER_EN
  tmr_wr_t tmr_wr;
  assign tmr_wr.th   = wr_sel && (off == OFF_TH);
  assign tmr_wr.tl   = wr_sel && (off == OFF_TL);
  assign tmr_wr.tcon = wr_sel && (off == OFF_TCON);

  periph_timer u_timer (
    .clk_i   (clk),
    .rst_ni  (reset),
    .wr_i    (tmr_wr),
    .wdata_i (wdata),
    .th_o    (th_rd),
    .tl_o    (tl_rd),
    .tcon_o  (tcon_rd),
    .irq_o   (irqout)
  );
`else
  assign th_rd   = '0;
  assign tl_rd   = '0;
  assign tcon_rd = '0;
  assign irqout  = 1'b0;

  logic unused_wdata;
  assign unused_wdata = ^wdata[DATA_W-1:DIGI_W];
`endif

  // Register state
  logic [LED_W-1:0]   led_q, led_d;
  logic [DIGI_W-1:0]  digi_q, digi_d;
  logic [RXCNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [BYTE_W-1:0]  rx0_q, rx0_d;
  logic [BYTE_W-1:0]  rx1_q, rx1_d;
  logic [BYTE_W-1:0]  tx_data_q, tx_data_d;
  logic [BYTE_W-1:0]  tx_hold_q, tx_hold_d;
  logic               tx_pend_q, tx_pend_d;
  logic               tx_start_q, tx_start_d;

  logic               rx_clr;
  logic               txd_wr;
  logic               can_launch;
  logic [RXCNT_W-1:0] rx_cnt_eff;

  assign rx_clr = rd_sel && (off == OFF_RX1);
  assign txd_wr = wr_sel && (off == OFF_TXD);

  // GPIO stores
  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    if (wr_sel && (off == OFF_LED))  led_d  = wdata[LED_W-1:0];
    if (wr_sel && (off == OFF_DIGI)) digi_d = wdata[DIGI_W-1:0];
  end

  // RX capture: a clearing load of RX1 takes effect before the new byte.
  always_comb begin
    rx0_d      = rx0_q;
    rx1_d      = rx1_q;
    rx_cnt_eff = rx_clr ? RXCNT_W'(0) : rx_cnt_q;
    rx_cnt_d   = rx_cnt_eff;
    if (rx_valid) begin
      if (rx_cnt_eff == RXCNT_W'(0)) begin
        rx0_d    = rx_data;
        rx_cnt_d = RXCNT_W'(1);
      end else if (rx_cnt_eff == RXCNT_W'(1)) begin
        rx1_d    = rx_data;
        rx_cnt_d = RXCNT_W'(2);
      end
    end
  end

  // TX holding buffer. A launch is blocked while tx_start is still high so the
  // transmitter has a cycle to raise tx_busy before a second byte can go out.
  always_comb begin
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    tx_hold_d  = tx_hold_q;
    tx_pend_d  = tx_pend_q;
    can_launch = !tx_busy && !tx_start_q;
    if (tx_pend_q && can_launch) begin
      tx_data_d  = tx_hold_q;
      tx_start_d = 1'b1;
      tx_pend_d  = 1'b0;
    end
    if (txd_wr) begin
      if (can_launch && !tx_pend_q) begin
        tx_data_d  = wdata[BYTE_W-1:0];
        tx_start_d = 1'b1;
      end else begin
        tx_hold_d = wdata[BYTE_W-1:0];
        tx_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      led_q      <= '0;
      digi_q     <= '0;
      rx_cnt_q   <= '0;
      rx0_q      <= '0;
      rx1_q      <= '0;
      tx_data_q  <= '0;
      tx_hold_q  <= '0;
      tx_pend_q  <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      led_q      <= led_d;
      digi_q     <= digi_d;
      rx_cnt_q   <= rx_cnt_d;
      rx0_q      <= rx0_d;
      rx1_q      <= rx1_d;
      tx_data_q  <= tx_data_d;
      tx_hold_q  <= tx_hold_d;
      tx_pend_q  <= tx_pend_d;
      tx_start_q <= tx_start_d;
    end
  end

  // Combinational read mux
  always_comb begin
    rdata = '0;
    if (rd_sel) begin
      case (off)
        OFF_TH:     rdata = th_rd;
        OFF_TL:     rdata = tl_rd;
        OFF_TCON:   rdata = DATA_W'(tcon_rd);
        OFF_LED:    rdata = DATA_W'(led_q);
        OFF_SW:     rdata = DATA_W'(switch);
        OFF_DIGI:   rdata = DATA_W'(digi_q);
        OFF_RXCNT:  rdata = DATA_W'(rx_cnt_q);
        OFF_RX0:    rdata = DATA_W'(rx0_q);
        OFF_RX1:    rdata = DATA_W'(rx1_q);
        OFF_TXSTAT: rdata = DATA_W'({tx_pend_q, tx_busy});
        default:    rdata = '0;
      endcase
    end
  end

  assign led      = led_q;
  assign digi     = digi_q;
  assign tx_data  = tx_data_q;
  assign tx_start = tx_start_q;

endmodule

// File: tb/tb_periph_bus.sv
// tb_periph_bus: directed self-checking bench for periph_bus.
// Timer expectations follow the PERIPH_TIMER_EN build setting.
module tb_periph_bus;

  localparam logic [31:0] A_TH     = 32'h4000_0000;
  localparam logic [31:0] A_TL     = 32'h4000_0004;
  localparam logic [31:0] A_TCON   = 32'h4000_0008;
  localparam logic [31:0] A_LED    = 32'h4000_000C;
  localparam logic [31:0] A_SW     = 32'h4000_0010;
  localparam logic [31:0] A_DIGI   = 32'h4000_0014;
  localparam logic [31:0] A_RXCNT  = 32'h4000_0018;
  localparam logic [31:0] A_RX0    = 32'h4000_001C;
  localparam logic [31:0] A_RX1    = 32'h4000_0020;
  localparam logic [31:0] A_TXD    = 32'h4000_0024;
  localparam logic [31:0] A_TXSTAT = 32'h4000_0028;

  logic        clk;
  logic        reset;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irqout;
  logic [7:0]  led;
  logic [7:0]  switch;
  logic [11:0] digi;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;

  int checks = 0;
  int errors = 0;

  periph_bus dut (
    .clk      (clk),
    .reset    (reset),
    .rd       (rd),
    .wr       (wr),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .irqout   (irqout),
    .led      (led),
    .switch   (switch),
    .digi     (digi),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .tx_busy  (tx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every task starts and ends 1 time unit after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; wr = 1'b1;
    @(posedge clk); #1;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a; rd = 1'b1;
    #2 d = rdata;
    @(posedge clk); #1;
    rd = 1'b0;
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({led, digi, tx_data, tx_start, irqout} !== 30'd0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", {led, digi, tx_data, tx_start, irqout}); end
    reset = 1'b1;
    @(posedge clk); #1;
    bus_read(A_TH, d);    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_th: got %h expected 0", d); end
    bus_read(A_TL, d);    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_tl: got %h expected 0", d); end
    bus_read(A_TCON, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_tcon: got %h expected 0", d); end
    bus_read(A_RXCNT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rxcnt: got %h expected 0", d); end
    bus_read(A_RX0, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_rx0: got %h expected 0", d); end
    bus_read(A_TXSTAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_txstat: got %h expected 0", d); end
  endtask

`ifdef PERIPH_TIMER_EN
  task automatic test_timer;
    logic [31:0] d;
    bus_write(A_TH, 32'hFFFF_FFFC);
    bus_write(A_TL, 32'hFFFF_FFFE);
    bus_write(A_TCON, 32'h3);
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL tmr_irq_c0: got %b expected 0", irqout); end
    bus_read(A_TL, d);    checks++; if (d !== 32'hFFFF_FFFE) begin errors++; $display("FAIL tmr_tl_c0: got %h expected fffffffe", d); end
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL tmr_irq_c1: got %b expected 0", irqout); end
    bus_read(A_TL, d);    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmr_tl_c1: got %h expected ffffffff", d); end
    checks++; if (irqout !== 1'b1) begin errors++; $display("FAIL tmr_irq_c2: got %b expected 1", irqout); end
    bus_read(A_TL, d);    checks++; if (d !== 32'hFFFF_FFFC) begin errors++; $display("FAIL tmr_reload: got %h expected fffffffc", d); end
    bus_read(A_TL, d);    checks++; if (d !== 32'hFFFF_FFFD) begin errors++; $display("FAIL tmr_th_plus1: got %h expected fffffffd", d); end
    bus_read(A_TCON, d);  checks++; if (d !== 32'h7) begin errors++; $display("FAIL tmr_tcon_is: got %h expected 7", d); end
    bus_write(A_TCON, 32'h0);
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL tmr_irq_clear: got %b expected 0", irqout); end
    // CPU write to TL beats the increment on the same edge
    bus_write(A_TCON, 32'h1);
    bus_write(A_TL, 32'h5);
    bus_read(A_TL, d);    checks++; if (d !== 32'h5) begin errors++; $display("FAIL tmr_write_wins: got %h expected 5", d); end
    bus_read(A_TL, d);    checks++; if (d !== 32'h6) begin errors++; $display("FAIL tmr_inc: got %h expected 6", d); end
    // Reload with interrupts disabled leaves status clear
    bus_write(A_TCON, 32'h0);
    bus_write(A_TH, 32'h10);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_write(A_TCON, 32'h1);
    bus_read(A_TL, d);    checks++; if (d !== 32'hFFFF_FFFF) begin errors++; $display("FAIL tmr_noie_pre: got %h expected ffffffff", d); end
    bus_read(A_TL, d);    checks++; if (d !== 32'h10) begin errors++; $display("FAIL tmr_noie_reload: got %h expected 10", d); end
    bus_read(A_TCON, d);  checks++; if (d !== 32'h1) begin errors++; $display("FAIL tmr_noie_tcon: got %h expected 1", d); end
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL tmr_noie_irq: got %b expected 0", irqout); end
    bus_write(A_TCON, 32'h0);
  endtask
`else
  task automatic test_timer;
    logic [31:0] d;
    bus_write(A_TCON, 32'h3);
    bus_write(A_TH, 32'h5);
    bus_write(A_TL, 32'hFFFF_FFFF);
    bus_read(A_TCON, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL notmr_tcon: got %h expected 0", d); end
    bus_read(A_TH, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL notmr_th: got %h expected 0", d); end
    bus_read(A_TL, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL notmr_tl: got %h expected 0", d); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (irqout !== 1'b0) begin errors++; $display("FAIL notmr_irq: got %b expected 0", irqout); end
  endtask
`endif

  task automatic test_rx;
    logic [31:0] d;
    rx_byte(8'h24);
    rx_byte(8'h3C);
    bus_read(A_RXCNT, d); checks++; if (d !== 32'h2)  begin errors++; $display("FAIL rx_cnt2: got %h expected 2", d); end
    bus_read(A_RX0, d);   checks++; if (d !== 32'h24) begin errors++; $display("FAIL rx_rx0: got %h expected 24", d); end
    bus_read(A_RX1, d);   checks++; if (d !== 32'h3C) begin errors++; $display("FAIL rx_rx1: got %h expected 3c", d); end
    bus_read(A_RXCNT, d); checks++; if (d !== 32'h0)  begin errors++; $display("FAIL rx_clear: got %h expected 0", d); end
    bus_read(A_RX1, d);   checks++; if (d !== 32'h3C) begin errors++; $display("FAIL rx_rx1_kept: got %h expected 3c", d); end
    // Overrun: third byte dropped
    rx_byte(8'h11);
    rx_byte(8'h22);
    rx_byte(8'hFF);
    bus_read(A_RXCNT, d); checks++; if (d !== 32'h2)  begin errors++; $display("FAIL rx_ovr_cnt: got %h expected 2", d); end
    bus_read(A_RX0, d);   checks++; if (d !== 32'h11) begin errors++; $display("FAIL rx_ovr_rx0: got %h expected 11", d); end
    // Clearing load and new byte in the same cycle
    addr = A_RX1; rd = 1'b1; rx_data = 8'h77; rx_valid = 1'b1;
    #2 d = rdata;
    @(posedge clk); #1;
    rd = 1'b0; rx_valid = 1'b0;
    checks++; if (d !== 32'h22) begin errors++; $display("FAIL rx_ovr_rx1: got %h expected 22", d); end
    bus_read(A_RXCNT, d); checks++; if (d !== 32'h1)  begin errors++; $display("FAIL rx_clr_and_valid_cnt: got %h expected 1", d); end
    bus_read(A_RX0, d);   checks++; if (d !== 32'h77) begin errors++; $display("FAIL rx_clr_and_valid_rx0: got %h expected 77", d); end
    bus_read(A_RX1, d);   checks++; if (d !== 32'h22) begin errors++; $display("FAIL rx_clr_and_valid_rx1: got %h expected 22", d); end
  endtask

  task automatic test_tx;
    logic [31:0] d;
    int          n;
    int          first;
    logic [7:0]  data;
    // Write while busy, then release
    tx_busy = 1'b1;
    bus_write(A_TXD, 32'h0C);
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_busy_nostart: got %b expected 0", tx_start); end
    bus_read(A_TXSTAT, d); checks++; if (d !== 32'h3) begin errors++; $display("FAIL tx_stat_pend: got %h expected 3", d); end
    tx_busy = 1'b0;
    n = 0; first = -1; data = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        n++;
        if (first < 0) begin first = i; data = tx_data; end
        tx_busy = 1'b1;
      end
    end
    tx_busy = 1'b0;
    checks++; if (n !== 1)       begin errors++; $display("FAIL tx_pend_count: got %0d expected 1", n); end
    checks++; if (first !== 0)   begin errors++; $display("FAIL tx_pend_when: got %0d expected 0", first); end
    checks++; if (data !== 8'h0C) begin errors++; $display("FAIL tx_pend_data: got %h expected 0c", data); end
    bus_read(A_TXSTAT, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL tx_stat_idle: got %h expected 0", d); end
    // Write while idle launches directly
    bus_write(A_TXD, 32'h55);
    checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL tx_idle_start: got %b expected 1", tx_start); end
    checks++; if (tx_data !== 8'h55) begin errors++; $display("FAIL tx_idle_data: got %h expected 55", tx_data); end
    @(posedge clk); #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL tx_idle_oneshot: got %b expected 0", tx_start); end
    // Overwrite of a pending byte gives one launch with the newest byte
    tx_busy = 1'b1;
    bus_write(A_TXD, 32'h01);
    bus_write(A_TXD, 32'h02);
    tx_busy = 1'b0;
    n = 0; data = 8'h00;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) begin
        n++; data = tx_data; tx_busy = 1'b1;
      end
    end
    tx_busy = 1'b0;
    checks++; if (n !== 1)        begin errors++; $display("FAIL tx_ovw_count: got %0d expected 1", n); end
    checks++; if (data !== 8'h02) begin errors++; $display("FAIL tx_ovw_data: got %h expected 02", data); end
    // Reset while a byte is pending drops it
    tx_busy = 1'b1;
    bus_write(A_TXD, 32'h99);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    tx_busy = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (tx_start === 1'b1) n++;
    end
    checks++; if (n !== 0)        begin errors++; $display("FAIL tx_reset_drop: got %0d expected 0", n); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL tx_reset_data: got %h expected 00", tx_data); end
    bus_read(A_TXD, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL txd_read: got %h expected 0", d); end
  endtask

  task automatic test_gpio;
    logic [31:0] d;
    switch = 8'h5A;
    bus_write(A_LED, 32'hFFFF_FFA5);
    bus_write(A_DIGI, 32'h0000_01C0);
    checks++; if (led !== 8'hA5)    begin errors++; $display("FAIL gpio_led_port: got %h expected a5", led); end
    checks++; if (digi !== 12'h1C0) begin errors++; $display("FAIL gpio_digi_port: got %h expected 1c0", digi); end
    bus_read(A_LED, d);  checks++; if (d !== 32'hA5)  begin errors++; $display("FAIL gpio_led_read: got %h expected a5", d); end
    bus_read(A_DIGI, d); checks++; if (d !== 32'h1C0) begin errors++; $display("FAIL gpio_digi_read: got %h expected 1c0", d); end
    bus_read(A_SW, d);   checks++; if (d !== 32'h5A)  begin errors++; $display("FAIL gpio_sw_read: got %h expected 5a", d); end
    bus_write(A_SW, 32'hFF);
    checks++; if ({led, digi} !== 20'hA51C0) begin errors++; $display("FAIL gpio_sw_store: got %h expected a51c0", {led, digi}); end
    bus_read(A_SW, d);   checks++; if (d !== 32'h5A)  begin errors++; $display("FAIL gpio_sw_ro: got %h expected 5a", d); end
    // Outside the window: store ignored, load returns 0
    bus_write(32'h4000_004C, 32'h33);
    checks++; if (led !== 8'hA5) begin errors++; $display("FAIL decode_wr: got %h expected a5", led); end
    bus_read(32'h4000_004C, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL decode_rd: got %h expected 0", d); end
    bus_read(32'h4000_002C, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got %h expected 0", d); end
    addr = A_LED; rd = 1'b0;
    #1;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rdata_no_rd: got %h expected 0", rdata); end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    switch = '0; rx_data = '0; rx_valid = 1'b0; tx_busy = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_timer();
    test_rx();
    test_tx();
    test_gpio();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
